result_accumulator: RTL and testbench

- Downstream stage of the 8-bit combinational adder in the counter exercise; consumes its `result` bus as a stream of samples.
- Accumulates COUNT consecutive accepted samples into a running sum and counts them.
- Presents the batch sum and an overflow flag on a valid/ready output, then starts the next batch.
- Turns the purely combinational add path into a registered, handshaked counter/accumulator.

---
 rtl/acc_pkg.sv | 12 +
 rtl/acc_add.sv | 27 ++
 rtl/result_accumulator.sv | 92 +++++++++
 tb/tb_result_accumulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants for the result accumulator: FSM state encoding and default sizing.
package acc_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_COUNT = 4;
   localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/acc_add.sv
// Next-sum adder with carry-out. Build macro ACC_SATURATE_EN clamps the sum to all-ones on carry
// instead of wrapping modulo 2^WIDTH.
module acc_add
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   logic [WIDTH:0] full;

   always_comb begin
      full    = {1'b0, a_i} + {1'b0, b_i};
      carry_o = full[WIDTH];
`ifdef ACC_SATURATE_EN
      // A saturated sum stays at all-ones: any further non-zero addend carries again.
      sum_o   = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
      sum_o   = full[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/result_accumulator.sv
// Batches COUNT accepted samples into a registered sum with sticky overflow, offered on a
// valid/ready output. Optional clamping arithmetic via build macro ACC_SATURATE_EN.
module result_accumulator
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned COUNT = DEF_COUNT,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_carry;

   acc_add #(.WIDTH(WIDTH)) u_add (
      .a_i     (sum_q),
      .b_i     (in_data),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   // Outputs decode registered state only, so nothing on in_* reaches out_* combinationally.
   assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      // NOTE: every next-state signal gets a hold-value default first, so no path infers a latch.
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sum_d   = in_data;
               ovf_d   = 1'b0;
               cnt_d   = CNT_W'(1);
               state_d = (COUNT == 1) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               sum_d = add_sum;
               ovf_d = ovf_q | add_carry;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST) state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator: directed vector table, corner sequences,
// and randomized traffic checked against a batch-level reference model.
module tb_result_accumulator;

   localparam int COUNT = 4;
`ifdef ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, out_ovf;
   logic [7:0] out_sum;

   logic       v1 = 1'b0;
   logic [7:0] d1 = 8'd0;
   logic       r1 = 1'b1;
   logic       ir1, ov1, of1;
   logic [7:0] os1;

   always #5 clk = ~clk;

   result_accumulator #(.WIDTH(8), .COUNT(COUNT), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
   );

   result_accumulator #(.WIDTH(8), .COUNT(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1), .in_data(d1),
      .out_valid(ov1), .out_ready(r1), .out_sum(os1), .out_ovf(of1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result of a batch: the true total decides both overflow and the presented sum.
   function automatic logic [8:0] batch_result(input int samples[$]);
      int total = 0;
      foreach (samples[i]) total += samples[i];
      if (total > 255) return {1'b1, SAT ? 8'd255 : 8'(total % 256)};
      return {1'b0, 8'(total)};
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Batch-level model: collected samples and whether a finished batch is on offer.
   int         batch[$];
   bit         m_hold = 1'b0;
   int         cap_n = 0;
   int         cap_cyc = 0;
   logic [7:0] cap_sum = 8'd0;
   logic       cap_ovf = 1'b0;

   always @(negedge clk) begin
      logic [8:0] r;
      if (reset) begin
         batch.delete();
         m_hold = 1'b0;
      end
      check("mon_in_ready", 32'(in_ready), 32'(!m_hold));
      check("mon_out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold) begin
         r = batch_result(batch);
         check("mon_out_sum", 32'(out_sum), 32'(r[7:0]));
         check("mon_out_ovf", 32'(out_ovf), 32'(r[8]));
      end
      if (out_valid && out_ready) begin
         cap_n++;
         cap_cyc = cyc;
         cap_sum = out_sum;
         cap_ovf = out_ovf;
      end
      if (!reset) begin
         if (m_hold) begin
            if (out_ready) begin
               m_hold = 1'b0;
               batch.delete();
            end
         end else if (in_valid) begin
            batch.push_back(int'(in_data));
            if (batch.size() == COUNT) m_hold = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int last_drive = 0;

   task automatic feed(input logic [3:0][7:0] s, input int gap, input logic rdy);
      for (int i = 3; i >= 0; i--) begin
         in_valid   = 1'b1;
         in_data    = s[i];
         out_ready  = rdy;
         last_drive = cyc;
         tick();
         in_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   typedef struct {
      logic [3:0][7:0] s;
      int              gap;
      logic [7:0]      exp_sum;
      logic            exp_ovf;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] held;
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] held;
      vecs[0] = '{s: {8'd1, 8'd2, 8'd3, 8'd4},       gap: 0, exp_sum: 8'd10, exp_ovf: 1'b0};
      vecs[1] = '{s: {8'd200, 8'd100, 8'd0, 8'd0},   gap: 0, exp_sum: SAT ? 8'd255 : 8'd44, exp_ovf: 1'b1};
      vecs[2] = '{s: {8'd1, 8'd2, 8'd3, 8'd4},       gap: 2, exp_sum: 8'd10, exp_ovf: 1'b0};
      vecs[3] = '{s: {8'd255, 8'd1, 8'd0, 8'd0},     gap: 1, exp_sum: SAT ? 8'd255 : 8'd0, exp_ovf: 1'b1};
      vecs[4] = '{s: {8'd128, 8'd128, 8'd128, 8'd127}, gap: 0, exp_sum: 8'd255, exp_ovf: 1'b1};
      vecs[5] = '{s: {8'd255, 8'd0, 8'd0, 8'd0},     gap: 0, exp_sum: 8'd255, exp_ovf: 1'b0};

      // Reset state while reset is held.
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_cnt", 32'(u_dut.cnt_q), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      foreach (vecs[k]) begin
         cap_n = 0;
         feed(vecs[k].s, vecs[k].gap, 1'b1);
         repeat (3) tick();
         check($sformatf("vec%0d_out_count", k), 32'(cap_n), 32'd1);
         check($sformatf("vec%0d_latency", k), 32'(cap_cyc), 32'(last_drive + 1));
         check($sformatf("vec%0d_sum", k), 32'(cap_sum), 32'(vecs[k].exp_sum));
         check($sformatf("vec%0d_ovf", k), 32'(cap_ovf), 32'(vecs[k].exp_ovf));
      end

      // Backpressure: held batch stays put while a sample waits upstream.
      feed({8'd1, 8'd1, 8'd1, 8'd1}, 0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'd7;
      @(negedge clk);
      held = out_sum;
      check("bp_held_sum", 32'(held), 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_sum_stable", 32'(out_sum), 32'(held));
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd0);
      tick();
      @(negedge clk);
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cap_n = 0;
      @(negedge clk);
      check("bp_first_cnt", 32'(u_dut.cnt_q), 32'd1);
      check("bp_first_sum", 32'(out_sum), 32'd7);
      tick();
      feed({8'd1, 8'd2, 8'd3, 8'd0}, 0, 1'b1);
      repeat (3) tick();
      check("bp_batch_count", 32'(cap_n), 32'd1);
      check("bp_batch_sum", 32'(cap_sum), 32'd13);

      // Reset in the middle of a batch discards it.
      in_valid = 1'b1;
      in_data  = 8'd9;
      tick();
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      cap_n    = 0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_cnt", 32'(u_dut.cnt_q), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("mid_rst_no_output", 32'(cap_n), 32'd0);
      feed({8'd5, 8'd5, 8'd5, 8'd5}, 0, 1'b1);
      repeat (3) tick();
      check("mid_rst_count", 32'(cap_n), 32'd1);
      check("mid_rst_sum", 32'(cap_sum), 32'd20);
      check("mid_rst_ovf", 32'(cap_ovf), 32'd0);

      // COUNT=1 instance: every sample is its own batch.
      v1 = 1'b1;
      d1 = 8'd250;
      tick();
      v1 = 1'b0;
      @(negedge clk);
      check("c1_a_valid", 32'(ov1), 32'd1);
      check("c1_a_in_ready", 32'(ir1), 32'd0);
      check("c1_a_sum", 32'(os1), 32'd250);
      check("c1_a_ovf", 32'(of1), 32'd0);
      tick();
      @(negedge clk);
      check("c1_a_done", 32'(ov1), 32'd0);
      tick();
      v1 = 1'b1;
      d1 = 8'd3;
      tick();
      v1 = 1'b0;
      @(negedge clk);
      check("c1_b_valid", 32'(ov1), 32'd1);
      check("c1_b_sum", 32'(os1), 32'd3);
      check("c1_b_ovf", 32'(of1), 32'd0);
      tick();

      // Randomized traffic with random backpressure, checked by the model.
      for (int i = 0; i < 1500; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                                 : 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
